// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/status bundle for sync_fifo_ctrl: the writer/reader side is the master and the FIFO
// is the slave.
interface sync_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr_en;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wdata, wr_en, rd_en, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wdata, wr_en, rd_en, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read port.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int unsigned FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AfullCnt  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AemptyCnt = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, wr_ok, rd_ok;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign rd_ok = bus.rd_en & ~empty;
  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign wr_ok = bus.wr_en & (~full | rd_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rptr_d = rptr_q + ADDR_WIDTH'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear.
    overflow_d  = (bus.wr_en & ~wr_ok) | (overflow_q & ~bus.clr_err);
    underflow_d = (bus.rd_en & ~rd_ok) | (underflow_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= bus.wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata  = mem_q[rptr_q];
  assign bus.rvalid = ~empty;
`else
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_ok;
      if (rd_ok) rdata_q <= mem_q[rptr_q];
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfullCnt);
  assign bus.almost_empty = (count_q <= AemptyCnt);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
